// File: rtl/neighbor_fetch.sv
// neighbor_fetch: upstream feeder for tile_check in the Trax move-validation path.
//
// Accepts a target board cell, reads the cell and its four orthogonal neighbours
// from board RAM (one read per cycle, data returned one cycle later), presents
// the neighbours to tile_check with a one-cycle start pulse, waits (bounded) for
// its answer and returns the legal-tile mask over a valid/ready handshake.
//
// Optional feature macro: NEIGHBOR_FETCH_EMPTY_SHORTCUT_EN
//   When defined, an empty target with four empty neighbours answers the
//   all-legal mask directly after CAP without involving tile_check.
//
// Ports:
//   clock, reset                 clock (rising edge), async active-high reset
//   req_valid/req_ready          request handshake; req_row/req_col target cell
//   mem_rd_en/mem_rd_addr        board RAM read port; mem_rd_data one cycle later
//   up/down/left/right_tile      neighbour codes to tile_check (7 = empty/off-board)
//   start_signal                 one-cycle start pulse to tile_check
//   end_signal, tile_type        tile_check done strobe and legal mask
//   rsp_valid/rsp_ready          response handshake
//   rsp_mask                     legal tile mask
//   rsp_forced                   rsp_mask has exactly one bit set
//   rsp_occupied                 target cell already holds a tile
//   rsp_timeout                  tile_check did not answer in time

module neighbor_fetch #(
    parameter int unsigned BOARD_W = 8,
    parameter int unsigned BOARD_H = 8,
    parameter int unsigned COORD_W = 3,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_row,
    input  logic [COORD_W-1:0] req_col,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [2:0]         mem_rd_data,
    output logic [2:0]         up_tile,
    output logic [2:0]         down_tile,
    output logic [2:0]         left_tile,
    output logic [2:0]         right_tile,
    output logic               start_signal,
    input  logic               end_signal,
    input  logic [5:0]         tile_type,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [5:0]         rsp_mask,
    output logic               rsp_forced,
    output logic               rsp_occupied,
    output logic               rsp_timeout
);

    localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  EMPTY     = 3'd7;
    localparam logic [5:0]  ALL_LEGAL = 6'b111111;

    typedef enum logic [3:0] {
        IDLE,
        RD_SELF,
        RD_UP,
        RD_DOWN,
        RD_LEFT,
        RD_RIGHT,
        CAP,
        START,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [COORD_W-1:0] row_q;
    logic [COORD_W-1:0] col_q;
    logic [2:0]         self_q;
    logic [CNT_W-1:0]   cnt;

    logic               at_top;
    logic               at_bottom;
    logic               at_left;
    logic               at_right;
    logic [2:0]         right_cap;
    logic               nbrs_empty;
    logic               nbrs_empty_cap;

    // Codes 6 and 7 both mean "no tile".
    function automatic logic is_empty(input logic [2:0] code);
        return code >= 3'd6;
    endfunction

    function automatic logic is_onehot(input logic [5:0] m);
        return (m != 6'd0) && ((m & (m - 6'd1)) == 6'd0);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [COORD_W-1:0] r,
                                                   input logic [COORD_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(BOARD_W) + ADDR_W'(c);
    endfunction

    // Board-edge detection for the latched target.
    always_comb begin
        at_top    = (row_q == '0);
        at_bottom = (row_q == COORD_W'(BOARD_H - 1));
        at_left   = (col_q == '0);
        at_right  = (col_q == COORD_W'(BOARD_W - 1));
    end

    // Right neighbour arrives in CAP; the empty test must see it before it is registered.
    always_comb begin
        right_cap      = at_right ? EMPTY : mem_rd_data;
        nbrs_empty     = is_empty(up_tile) && is_empty(down_tile) &&
                         is_empty(left_tile) && is_empty(right_tile);
        nbrs_empty_cap = is_empty(up_tile) && is_empty(down_tile) &&
                         is_empty(left_tile) && is_empty(right_cap);
    end

    // Control FSM with registered outputs; reads are pipelined with data capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            self_q       <= EMPTY;
            cnt          <= '0;
            req_ready    <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_rd_addr  <= '0;
            up_tile      <= EMPTY;
            down_tile    <= EMPTY;
            left_tile    <= EMPTY;
            right_tile   <= EMPTY;
            start_signal <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_mask     <= '0;
            rsp_forced   <= 1'b0;
            rsp_occupied <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            mem_rd_en    <= 1'b0;
            start_signal <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        row_q       <= req_row;
                        col_q       <= req_col;
                        req_ready   <= 1'b0;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= addr_of(req_row, req_col);
                        state       <= RD_SELF;
                    end
                end
                RD_SELF: begin
                    if (!at_top) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= addr_of(row_q - COORD_W'(1), col_q);
                    end
                    state <= RD_UP;
                end
                RD_UP: begin
                    self_q <= mem_rd_data;
                    if (!at_bottom) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= addr_of(row_q + COORD_W'(1), col_q);
                    end
                    state <= RD_DOWN;
                end
                RD_DOWN: begin
                    up_tile <= at_top ? EMPTY : mem_rd_data;
                    if (!at_left) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= addr_of(row_q, col_q - COORD_W'(1));
                    end
                    state <= RD_LEFT;
                end
                RD_LEFT: begin
                    down_tile <= at_bottom ? EMPTY : mem_rd_data;
                    if (!at_right) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= addr_of(row_q, col_q + COORD_W'(1));
                    end
                    state <= RD_RIGHT;
                end
                RD_RIGHT: begin
                    left_tile <= at_left ? EMPTY : mem_rd_data;
                    state     <= CAP;
                end
                CAP: begin
                    right_tile <= right_cap;
                    if (!is_empty(self_q)) begin
                        // Target already occupied: no placement possible.
                        rsp_valid    <= 1'b1;
                        rsp_mask     <= '0;
                        rsp_forced   <= 1'b0;
                        rsp_occupied <= 1'b1;
                        rsp_timeout  <= 1'b0;
                        state        <= RESP;
`ifdef NEIGHBOR_FETCH_EMPTY_SHORTCUT_EN
                    end else if (nbrs_empty_cap) begin
                        // Isolated empty cell: every tile is legal.
                        rsp_valid    <= 1'b1;
                        rsp_mask     <= ALL_LEGAL;
                        rsp_forced   <= 1'b0;
                        rsp_occupied <= 1'b0;
                        rsp_timeout  <= 1'b0;
                        state        <= RESP;
`endif
                    end else begin
                        start_signal <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    // end_signal during the start cycle is deliberately ignored.
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (end_signal) begin
                        rsp_valid    <= 1'b1;
                        rsp_mask     <= tile_type;
                        rsp_forced   <= is_onehot(tile_type);
                        rsp_occupied <= 1'b0;
                        rsp_timeout  <= 1'b0;
                        state        <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // A silent checker with no constraining neighbours still means all-legal.
                        rsp_valid    <= 1'b1;
                        rsp_mask     <= nbrs_empty ? ALL_LEGAL : 6'd0;
                        rsp_forced   <= 1'b0;
                        rsp_occupied <= 1'b0;
                        rsp_timeout  <= !nbrs_empty;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
